// File: rtl/data_mem_ctrl_pkg.sv
// Shared constants, funct3 codes and FSM encoding
// for the data memory / MMIO load-store controller.
package data_mem_ctrl_pkg;

  localparam int          DEF_RAM_ADDR_W = 14;
  localparam logic [31:0] DEF_IO_BASE    = 32'hFFFF_FC00;
  localparam logic [31:0] DEF_LED_ADDR   = 32'hFFFF_FC60;
  localparam logic [31:0] DEF_SW_ADDR    = 32'hFFFF_FC70;
  localparam logic [31:0] DEF_SEG_ADDR   = 32'hFFFF_FC80;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DONE
  } state_e;

  function automatic logic is_aligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b1;
    case (f3)
      F3_LH, F3_LHU: ok = ~off[0];
      F3_LW:         ok = (off == 2'b00);
      default:       ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_extend.sv
// Load lane select plus sign/zero extension
// of a 32-bit memory or IO word.
module data_mem_ctrl_load_extend
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word_i[8*off_i +: 8];
    h      = off_i[1] ? word_i[31:16]
                      : word_i[15:0];
    data_o = 32'h0;
    case (funct3_i)
      F3_LB:   data_o = {{24{b[7]}}, b};
      F3_LH:   data_o = {{16{h[15]}}, h};
      F3_LW:   data_o = word_i;
      F3_LBU:  data_o = {24'h0, b};
      F3_LHU:  data_o = {16'h0, h};
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store responder for data RAM and MMIO
// (LEDs, 7-seg, switches); stalls on RAM loads.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int          RAM_ADDR_W = DEF_RAM_ADDR_W,
  parameter logic [31:0] IO_BASE    = DEF_IO_BASE,
  parameter logic [31:0] LED_ADDR   = DEF_LED_ADDR,
  parameter logic [31:0] SW_ADDR    = DEF_SW_ADDR,
  parameter logic [31:0] SEG_ADDR   = DEF_SEG_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  stall,
  output logic                  misalign,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic [15:0]           switch_in,
  output logic [15:0]           led_out,
  output logic [31:0]           seg_out
);

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic [15:0] sw_meta_q, sw_meta_d;
  logic [15:0] sw_sync_q, sw_sync_d;

  logic        is_io;
  logic        aligned;
  logic        hit_led;
  logic        hit_sw;
  logic        hit_seg;
  logic [31:0] io_word;
  logic [31:0] ext_src;
  logic [31:0] ext_data;
  logic [3:0]  store_we;

  assign is_io    = (addr >= IO_BASE);
  assign aligned  = is_aligned(funct3, addr[1:0]);
  assign hit_led  = is_io && (addr[31:2] == LED_ADDR[31:2]);
  assign hit_sw   = is_io && (addr[31:2] == SW_ADDR[31:2]);
  assign hit_seg  = is_io && (addr[31:2] == SEG_ADDR[31:2]);
  assign ram_addr = addr[RAM_ADDR_W+1:2];
  assign led_out  = led_q;
  assign seg_out  = seg_q;

  always_comb begin
    io_word = 32'h0;
    unique case (1'b1)
      hit_sw:  io_word = {16'h0, sw_sync_q};
      hit_led: io_word = {16'h0, led_q};
      hit_seg: io_word = seg_q;
      default: io_word = 32'h0;
    endcase
  end

  // RAM data only reaches the extender while the read is in flight
  assign ext_src = (state_q == ST_RD_WAIT) ? ram_rdata
                                           : io_word;

  data_mem_ctrl_load_extend u_ext (
    .word_i   (ext_src),
    .off_i    (addr[1:0]),
    .funct3_i (funct3),
    .data_o   (ext_data)
  );

  always_comb begin
    ram_wdata = write_data;
    store_we  = 4'h0;
    case (funct3)
      F3_SB: begin
        ram_wdata = {4{write_data[7:0]}};
        store_we  = 4'b0001 << addr[1:0];
      end
      F3_SH: begin
        ram_wdata = {2{write_data[15:0]}};
        store_we  = addr[1] ? 4'b1100 : 4'b0011;
      end
      F3_SW:   store_we = 4'b1111;
      default: store_we = 4'h0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    led_d     = led_q;
    seg_d     = seg_q;
    sw_meta_d = switch_in;
    sw_sync_d = sw_meta_q;
    stall     = 1'b0;
    misalign  = 1'b0;
    ram_we    = 4'h0;
    read_data = 32'h0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_write) begin
          if (!aligned) begin
            misalign = 1'b1;
          end else if (is_io) begin
            if (hit_led) led_d = write_data[15:0];
            if (hit_seg) seg_d = write_data;
          end else begin
            ram_we = store_we;
          end
        end else if (mem_read) begin
          if (!aligned) begin
            misalign = 1'b1;
          end else if (is_io) begin
            read_data = ext_data;
          end else begin
            stall   = 1'b1;
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        stall   = 1'b1;
        rdata_d = ext_data;
        state_d = ST_RD_DONE;
      end
      ST_RD_DONE: begin
        read_data = rdata_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs read as reset values while rst is held
    if (rst) begin
      stall     = 1'b0;
      misalign  = 1'b0;
      ram_we    = 4'h0;
      read_data = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      seg_q     <= 32'h0;
      sw_meta_q <= 16'h0;
      sw_sync_q <= 16'h0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      seg_q     <= seg_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: RAM model,
// shadow byte memory and queued load expectations.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        misalign;
  logic [13:0] ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [15:0] switch_in;
  logic [15:0] led_out;
  logic [31:0] seg_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  shadow[logic [31:0]];
  logic [31:0] ram[0:16383];

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .stall      (stall),
    .misalign   (misalign),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .switch_in  (switch_in),
    .led_out    (led_out),
    .seg_out    (seg_out)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we[i])
        ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_rdata <= ram[ram_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  function automatic logic [7:0] sbyte(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_load(
    input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = sbyte(a);
    b1 = sbyte(a + 1);
    b2 = sbyte(a + 2);
    b3 = sbyte(a + 3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic idle_inputs();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    write_data = 32'h0;
  endtask

  task automatic ram_store(input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] d,
    input string name);
    logic [3:0] ew;
    bit ok;
    int n;
    ew = (f3 == 3'b000) ? 4'b0001 << a[1:0] :
         (f3 == 3'b001) ? 4'b0011 << a[1:0] : 4'b1111;
    n  = 1 << f3;
    for (int i = 0; i < n; i++)
      shadow[a + i] = d[8*i +: 8];
    @(negedge clk);
    mem_write = 1'b1; funct3 = f3;
    addr = a; write_data = d;
    #1;
    checks++;
    if (ram_we !== ew) begin
      failures++;
      $display("FAIL %s we: got %b exp %b", name, ram_we, ew);
    end
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (ew[i] && ram_wdata[8*i +: 8] !== sbyte({a[31:2], 2'(i)}))
        ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s wdata: got %h", name, ram_wdata);
    end
    checks++;
    if (stall !== 1'b0 || misalign !== 1'b0) begin
      failures++;
      $display("FAIL %s flags: stall %b misalign %b exp 0 0",
               name, stall, misalign);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_load(input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] exp,
    input int exp_stalls, input string name);
    int n;
    logic [31:0] got;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0;
    funct3 = f3; addr = a;
    exp_q.push_back(exp);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 8) begin
      n++;
      @(negedge clk); #1;
    end
    checks++;
    if (n != exp_stalls) begin
      failures++;
      $display("FAIL %s stalls: got %0d exp %0d", name, n, exp_stalls);
    end
    got = exp_q.pop_front();
    checks++;
    if (read_data !== got) begin
      failures++;
      $display("FAIL %s data: got %h exp %h", name, read_data, got);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic bad_access(input logic rd, input logic wr,
    input logic [2:0] f3, input logic [31:0] a,
    input string name);
    @(negedge clk);
    mem_read = rd; mem_write = wr;
    funct3 = f3; addr = a; write_data = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (misalign !== 1'b1 || stall !== 1'b0 ||
        ram_we !== 4'h0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL %s: got mis %b stall %b we %b rd %h exp 1 0 0000 0",
               name, misalign, stall, ram_we, read_data);
    end
    @(posedge clk); #1;
    idle_inputs();
    #1;
    checks++;
    if (misalign !== 1'b0) begin
      failures++;
      $display("FAIL %s pulse: got %b exp 0", name, misalign);
    end
  endtask

  task automatic io_store(input logic [31:0] a,
    input logic [31:0] d, input string name);
    @(negedge clk);
    mem_write = 1'b1; funct3 = F3_SW;
    addr = a; write_data = d;
    #1;
    checks++;
    if (ram_we !== 4'h0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL %s: got we %b stall %b exp 0000 0",
               name, ram_we, stall);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    switch_in = 16'h0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || misalign !== 1'b0 ||
        ram_we !== 4'h0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL reset outs: stall %b mis %b we %b rd %h exp 0",
               stall, misalign, ram_we, read_data);
    end
    checks++;
    if (led_out !== 16'h0 || seg_out !== 32'h0) begin
      failures++;
      $display("FAIL reset regs: led %h seg %h exp 0", led_out, seg_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_word();
    ram_store(F3_SW, 32'h100, 32'h1234_5678, "sw100");
    do_load(F3_LW, 32'h100, 32'h1234_5678, 2, "lw100");
  endtask

  task automatic test_byte();
    ram_store(F3_SB, 32'h103, 32'h0000_0080, "sb103");
    do_load(F3_LB, 32'h103, 32'hFFFF_FF80, 2, "lb103");
    do_load(F3_LBU, 32'h103, 32'h0000_0080, 2, "lbu103");
  endtask

  task automatic test_misalign();
    bad_access(1'b1, 1'b0, F3_LH, 32'h101, "lh101");
    bad_access(1'b0, 1'b1, F3_SW, 32'h102, "sw102");
    bad_access(1'b1, 1'b0, F3_LW, 32'hFFFF_FC62, "lw_io");
    do_load(F3_LW, 32'h100, 32'h8034_5678, 2, "lw_after_bad");
  endtask

  task automatic test_io();
    @(negedge clk);
    switch_in = 16'hA5A5;
    mem_read = 1'b1; funct3 = F3_LW; addr = DEF_SW_ADDR;
    @(posedge clk); #1;
    checks++;
    if (read_data !== 32'h0) begin
      failures++;
      $display("FAIL sw_sync1: got %h exp 0", read_data);
    end
    @(posedge clk); #1;
    checks++;
    if (read_data !== 32'h0000_A5A5 || stall !== 1'b0) begin
      failures++;
      $display("FAIL sw_sync2: got %h stall %b exp 0000a5a5 0",
               read_data, stall);
    end
    idle_inputs();
    do_load(F3_LW, DEF_SW_ADDR, 32'h0000_A5A5, 0, "lw_sw");
    io_store(DEF_LED_ADDR, 32'h0000_BEEF, "st_led");
    checks++;
    if (led_out !== 16'hBEEF) begin
      failures++;
      $display("FAIL led_out: got %h exp beef", led_out);
    end
    do_load(F3_LW, DEF_LED_ADDR, 32'h0000_BEEF, 0, "lw_led");
    io_store(DEF_SEG_ADDR, 32'hDEAD_BEEF, "st_seg");
    checks++;
    if (seg_out !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL seg_out: got %h exp deadbeef", seg_out);
    end
    do_load(F3_LB, DEF_SEG_ADDR + 3, 32'hFFFF_FFDE, 0, "lb_seg");
    do_load(F3_LHU, DEF_SEG_ADDR + 2, 32'h0000_DEAD, 0, "lhu_seg");
    do_load(F3_LW, 32'hFFFF_FC90, 32'h0, 0, "lw_unmapped");
    io_store(32'hFFFF_FC90, 32'h1111_1111, "st_unmapped");
    checks++;
    if (led_out !== 16'hBEEF || seg_out !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL unmapped st: led %h seg %h exp beef deadbeef",
               led_out, seg_out);
    end
  endtask

  task automatic test_reset_in_load();
    @(negedge clk);
    mem_read = 1'b1; funct3 = F3_LW; addr = 32'h100;
    @(posedge clk); #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL rst_load wait: got stall %b exp 1", stall);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (stall !== 1'b0 || read_data !== 32'h0 || led_out !== 16'h0) begin
      failures++;
      $display("FAIL rst_load: stall %b rd %h led %h exp 0 0 0",
               stall, read_data, led_out);
    end
    do_load(F3_LW, 32'h100, 32'h8034_5678, 2, "lw_after_rst");
  endtask

  task automatic test_rw_both();
    shadow[32'h202] = 8'hFE;
    shadow[32'h203] = 8'hCA;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b1;
    funct3 = F3_SH; addr = 32'h202; write_data = 32'h0000_CAFE;
    #1;
    checks++;
    if (ram_we !== 4'b1100 || ram_wdata !== 32'hCAFE_CAFE) begin
      failures++;
      $display("FAIL rw_both: we %b wd %h exp 1100 cafecafe",
               ram_we, ram_wdata);
    end
    checks++;
    if (stall !== 1'b0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL rw_both rd: stall %b rd %h exp 0 0", stall, read_data);
    end
    @(posedge clk); #1;
    idle_inputs();
    do_load(F3_LHU, 32'h202, 32'h0000_CAFE, 2, "lhu202");
    do_load(F3_LH, 32'h202, 32'hFFFF_CAFE, 2, "lh202");
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3;
    logic [31:0] a;
    logic [2:0]  lds[5];
    lds = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int w = 0; w < 4; w++)
      ram_store(F3_SW, 32'h400 + 4 * w, $urandom, "b2b_init");
    for (int k = 0; k < 30; k++) begin
      a = 32'h400 + $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        f3 = 3'($urandom_range(0, 2));
        a  = a & ~((32'd1 << f3) - 1);
        ram_store(f3, a, $urandom, "b2b_st");
      end else begin
        f3 = lds[$urandom_range(0, 4)];
        a  = a & ~((32'd1 << f3[1:0]) - 1);
        do_load(f3, a, ref_load(f3, a), 2, "b2b_ld");
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_misalign();
    test_io();
    test_reset_in_load();
    test_rw_both();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Load/store responder sitting between the ALU address output (ALUResult on load/S-type ops) and the data memory and memory-mapped IO. It decodes funct3 for byte, half and word access. It drives byte enables and lane shifts into a synchronous-read block RAM and stalls the core for RAM loads. It also owns the LED/segment output registers and the synchronized switch input.

Parameters:
RAM_ADDR_W, 14, word-address width of data RAM (64 KiB)
IO_BASE, 32'hFFFF_FC00, addresses >= IO_BASE decode to IO; all others decode to RAM
LED_ADDR, 32'hFFFF_FC60, LED output register
SW_ADDR, 32'hFFFF_FC70, switch input (read-only)
SEG_ADDR, 32'hFFFF_FC80, 7-seg value register

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
mem_read  in  1  load request; held stable by core while stall=1
mem_write  in  1  store request
funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
addr  in  32  byte address from ALU
write_data  in  32  rs2 value
read_data  out  32  load result, extended per funct3
stall  out  1  core must hold PC and pipeline inputs
misalign  out  1  one-cycle pulse on illegal alignment
ram_addr  out  RAM_ADDR_W  word address = addr[RAM_ADDR_W+1:2]
ram_we  out  4  byte-lane write enables
ram_wdata  out  32  lane-shifted store data
ram_rdata  in  32  RAM data, valid 1 cycle after address
switch_in  in  16  asynchronous board switches
led_out  out  16  LED register
seg_out  out  32  7-seg register

Behaviour:
- Reset: FSM=IDLE; read_data=0, stall=0, misalign=0, ram_we=0, led_out=0, seg_out=0, switch synchronizer=0. Reset during RD_WAIT or RD_DONE aborts the load: IDLE next cycle, no stall.
- Alignment: h/hu need addr[0]=0; w needs addr[1:0]=00; b/bu are always aligned. On violation the access is dropped: ram_we=0, no IO write, read_data=0, no stall, misalign=1 for that cycle.
- Stores (mem_write=1, IDLE) complete in a single cycle with no stall:
  - sb: ram_we = 0001 shifted left by addr[1:0]; ram_wdata = byte replicated on all 4 lanes.
  - sh: ram_we = 0011 shifted left by 2*addr[1]; ram_wdata = half replicated on both halves.
  - sw: ram_we = 1111.
  - IO store: LED_ADDR takes write_data[15:0]; SEG_ADDR takes write_data. Other IO addresses are ignored.
- RAM load FSM:
  - IDLE: mem_read with a RAM address sets stall=1 combinationally, presents ram_addr, goes to RD_WAIT.
  - RD_WAIT: stall=1; ram_rdata is selected by addr[1:0] and funct3, sign- or zero-extended, registered into read_data; goes to RD_DONE.
  - RD_DONE: stall=0; read_data holds its value; the core consumes it at this edge; goes to IDLE.
  - Total latency is 3 cycles with 2 stall cycles.
- IO load: single cycle, no stall. read_data is combinational in IDLE:
  - SW_ADDR: {16'b0, sw_sync}.
  - LED_ADDR and SEG_ADDR read back their registers.
  - Unmapped IO reads return 0.
- switch_in passes through a 2-FF synchronizer, so 2 cycles of latency before it is visible.
- mem_read and mem_write both high: the write is performed and the read is ignored (read_data=0, no stall).
- mem_read=mem_write=0: ram_we=0, read_data=0, stall=0.
- A new request that arrives in RD_DONE is accepted only after returning to IDLE. The core never issues one there, because stall deasserts only in RD_DONE.

Decomposition:
- Shared package/header: funct3 load/store codes (LB/LH/LW/LBU/LHU/SB/SH/SW), IO address constants, FSM state encoding.
- One natural sub-module, load_extend: combinational lane select plus sign/zero extension from ram_rdata/IO data, addr[1:0] and funct3.

Test Plan:
- sw 0x12345678 @0x100, then lw @0x100 -> stall high for 2 cycles; read_data=0x12345678 in the third cycle; ram_we=1111 on the store.
- sb 0x80 @0x103, then lb @0x103 and lbu @0x103 -> ram_we=1000; lb gives 0xFFFFFF80; lbu gives 0x00000080.
- lh @0x101 -> misalign=1 for 1 cycle, read_data=0, stall=0. sw @0x102 -> ram_we=0000, misalign=1.
- switch_in=0xA5A5, then lw @0xFFFFFC70 three cycles later -> read_data=0x0000A5A5 with no stall. sw 0x0000BEEF @0xFFFFFC60 -> led_out=0xBEEF next cycle.
- lw @0x100 with rst asserted in RD_WAIT -> next cycle state is IDLE, stall=0, read_data=0, led_out=0.
- mem_read=mem_write=1, sh 0xCAFE @0x202 -> ram_we=1100, ram_wdata=0xCAFECAFE, stall=0.
